// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet count of leading bytes from an AXI-Stream packet and realigns the payload.
// The header output channel is built only when AXIS_STRIP_HDR_OUT_EN is defined.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_strip,
  output logic                    ready_strip,
  input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
  output logic                    valid_hdr,
  input  logic                    ready_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    short_pkt
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] NB_C = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_STREAM, ST_FLUSH} state_t;

  function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] v, input logic [CW-1:0] n);
    return v << {n, 3'b000};
  endfunction

  function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] v, input logic [CW-1:0] n);
    return v >> {n, 3'b000};
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [CW-1:0] k);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ones << (NB_C - k);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_lsb(input logic [CW-1:0] k);
    logic [DATA_BYTE_WD-1:0] ones;
    ones = '1;
    return ~(ones << k);
  endfunction

  function automatic logic [CW-1:0] count_ones(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) n = n + CW'(k[i]);
    return n;
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           s_q, s_d;
  logic [CW-1:0]           rem_q, rem_d;
  logic [DATA_WD-1:0]      r_q, r_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    short_pkt_q, short_pkt_d;

  logic [DATA_WD-1:0] keep_bits;
  logic [DATA_WD-1:0] din_m;
  logic [DATA_WD-1:0] joined;
  logic [CW-1:0]      m_cnt;
  logic [CW-1:0]      hdr_cnt;
  logic               out_free;
  logic               hdr_free;
  logic               in_acc;
  logic               hdr_load;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep_bits
      assign keep_bits[gi*8 +: 8] = {8{keep_in[gi]}};
    end
  endgenerate

  // Bytes outside keep are zeroed so realigned beats never carry stale data.
  assign din_m    = data_in & keep_bits;
  assign m_cnt    = count_ones(keep_in);
  assign joined   = r_q | shr_bytes(din_m, NB_C - s_q);
  assign out_free = !valid_out_q || ready_out;
  assign in_acc   = valid_in && ready_in;
  assign hdr_load = (state_q == ST_FIRST) && in_acc && (s_q != '0);
  assign hdr_cnt  = (last_in && (m_cnt <= s_q)) ? m_cnt : s_q;

  always_comb begin
    ready_in = 1'b0;
    case (state_q)
      ST_FIRST:  ready_in = hdr_free && out_free;
      ST_STREAM: ready_in = out_free;
      default:   ready_in = 1'b0;
    endcase
  end

  // The next command waits until the final beat or short pulse of this packet has gone out.
  assign ready_strip = (state_q == ST_IDLE) && !valid_out_q && !short_pkt_q;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    rem_d       = rem_q;
    r_d         = r_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q && !(valid_out_q && ready_out);
    short_pkt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_strip && ready_strip) begin
          s_d     = (byte_strip_cnt > NB_C) ? NB_C : byte_strip_cnt;
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (in_acc) begin
          if (s_q == '0) begin
            valid_out_d = 1'b1;
            data_out_d  = data_in;
            keep_out_d  = keep_in;
            last_out_d  = last_in;
            state_d     = last_in ? ST_IDLE : ST_STREAM;
          end else if (last_in && (m_cnt <= s_q)) begin
            short_pkt_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (last_in) begin
            valid_out_d = 1'b1;
            data_out_d  = shl_bytes(din_m, s_q);
            keep_out_d  = keep_msb(m_cnt - s_q);
            last_out_d  = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            r_d     = shl_bytes(din_m, s_q);
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (in_acc) begin
          valid_out_d = 1'b1;
          if (s_q == '0) begin
            data_out_d = data_in;
            keep_out_d = keep_in;
            last_out_d = last_in;
            if (last_in) state_d = ST_IDLE;
          end else begin
            data_out_d = joined;
            keep_out_d = '1;
            last_out_d = 1'b0;
            r_d        = shl_bytes(din_m, s_q);
            if (last_in && (m_cnt <= s_q)) begin
              keep_out_d = keep_msb(NB_C - s_q + m_cnt);
              last_out_d = 1'b1;
              state_d    = ST_IDLE;
            end else if (last_in) begin
              rem_d   = m_cnt - s_q;
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          valid_out_d = 1'b1;
          data_out_d  = r_q;
          keep_out_d  = keep_msb(rem_q);
          last_out_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      rem_q       <= '0;
      r_q         <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '1;
      last_out_q  <= 1'b0;
      short_pkt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      rem_q       <= rem_d;
      r_q         <= r_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      short_pkt_q <= short_pkt_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign short_pkt = short_pkt_q;

`ifdef AXIS_STRIP_HDR_OUT_EN
  logic                    valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

  assign hdr_free = !valid_hdr_q || ready_hdr;

  // Short packets put only their M real bytes into the header.
  always_comb begin
    valid_hdr_d = valid_hdr_q && !ready_hdr;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    if (hdr_load) begin
      valid_hdr_d = 1'b1;
      data_hdr_d  = shr_bytes(din_m, NB_C - hdr_cnt);
      keep_hdr_d  = keep_lsb(hdr_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_hdr_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      valid_hdr_q <= valid_hdr_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign valid_hdr = valid_hdr_q;
  assign data_hdr  = data_hdr_q;
  assign keep_hdr  = keep_hdr_q;
`else
  logic unused_hdr;
  assign hdr_free   = 1'b1;
  assign valid_hdr  = 1'b0;
  assign data_hdr   = '0;
  assign keep_hdr   = '0;
  assign unused_hdr = ^{ready_hdr, hdr_load, hdr_cnt};
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Randomized bench for axi_stream_strip_header: byte-list reference model, backpressure and reset checks.
module tb_axi_stream_strip_header;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          valid_strip = 1'b0;
  logic          ready_strip;
  logic [CW-1:0] byte_strip_cnt = '0;
  logic          valid_hdr;
  logic          ready_hdr = 1'b1;
  logic [DW-1:0] data_hdr;
  logic [NB-1:0] keep_hdr;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          short_pkt;

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_strip(valid_strip), .ready_strip(ready_strip), .byte_strip_cnt(byte_strip_cnt),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .short_pkt(short_pkt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  beat_t      exp_out[$];
  beat_t      exp_hdr[$];
  logic [7:0] pkt[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_short = 0;
  int         seen_short = 0;
  int         stall_req = 0;
  bit         bp_mode = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] k);
    logic [DW-1:0] m;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Header = first min(S, len) bytes right-aligned; payload = bytes S.. chunked into MSB-aligned beats.
  task automatic model_push(input int s_raw);
    int    n, s, hb, cnt;
    beat_t b;
    n = pkt.size();
    s = (s_raw > NB) ? NB : s_raw;
    if (s > 0) begin
      hb = (n <= s) ? n : s;
      b.data = '0; b.keep = '0; b.last = 1'b0;
      for (int i = 0; i < hb; i++) begin
        b.data = (b.data << 8) | DW'(pkt[i]);
        b.keep = (b.keep << 1) | NB'(1);
      end
`ifdef AXIS_STRIP_HDR_OUT_EN
      exp_hdr.push_back(b);
`endif
    end
    if (s > 0 && n <= s) begin
      exp_short++;
    end else begin
      for (int p = s; p < n; p += NB) begin
        cnt = (n - p < NB) ? (n - p) : NB;
        b.data = '0; b.keep = '0;
        for (int j = 0; j < NB; j++) begin
          b.data = b.data << 8;
          b.keep = b.keep << 1;
          if (j < cnt) begin
            b.data[7:0] = pkt[p+j];
            b.keep[0]   = 1'b1;
          end
        end
        b.last = (p + NB >= n);
        exp_out.push_back(b);
      end
    end
  endtask

  task automatic run_packet(input int s_cmd, input int stop_after, input bit gaps);
    int            n, nb, t;
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    model_push(s_cmd);
    valid_strip    = 1'b1;
    byte_strip_cnt = CW'(s_cmd);
    t = 0;
    while (1) begin
      @(negedge clk);
      if (ready_strip) break;
      t++;
      if (t > 2000) begin
        check_val("strip_timeout", 64'(ready_strip), 1);
        break;
      end
    end
    @(posedge clk); #1;
    valid_strip    = 1'b0;
    byte_strip_cnt = '0;
    n  = pkt.size();
    nb = (n + NB - 1) / NB;
    for (int b = 0; b < nb; b++) begin
      if (stop_after >= 0 && b >= stop_after) break;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = '0; k = '0;
      for (int j = 0; j < NB; j++) begin
        d = d << 8;
        k = k << 1;
        if (b*NB + j < n) begin
          d[7:0] = pkt[b*NB + j];
          k[0]   = 1'b1;
        end else begin
          d[7:0] = 8'($urandom);
        end
      end
      valid_in = 1'b1; data_in = d; keep_in = k; last_in = (b == nb - 1);
      t = 0;
      while (1) begin
        @(negedge clk);
        if (ready_in) break;
        t++;
        if (t > 2000) begin
          check_val("in_timeout", 64'(ready_in), 1);
          break;
        end
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      last_in  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready_strip"}, 64'(ready_strip), 1);
    check_val({tag, "_ready_in"},    64'(ready_in), 0);
    check_val({tag, "_valid_out"},   64'(valid_out), 0);
    check_val({tag, "_valid_hdr"},   64'(valid_hdr), 0);
    check_val({tag, "_last_out"},    64'(last_out), 0);
    check_val({tag, "_short_pkt"},   64'(short_pkt), 0);
    check_val({tag, "_data_out"},    64'(data_out), 0);
    check_val({tag, "_data_hdr"},    64'(data_hdr), 0);
    check_val({tag, "_keep_out"},    64'(keep_out), 64'hF);
    check_val({tag, "_keep_hdr"},    64'(keep_hdr), 0);
  endtask

  // Sink: random or full-rate ready, with a forced ready_out stall window.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_req != 0) ready_out = 1'b0;
      else ready_out = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      ready_hdr = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic          prev_ostall = 1'b0;
  logic          prev_hstall = 1'b0;
  logic          prev_short  = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [NB-1:0] prev_keep = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_hdata = '0;
  logic [NB-1:0] prev_hkeep = '0;
  beat_t         mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ostall = 1'b0;
        prev_hstall = 1'b0;
        prev_short  = 1'b0;
      end else begin
        if (prev_ostall) begin
          check_val("out_hold_valid", 64'(valid_out), 1);
          check_val("out_hold_beat", {last_out, keep_out, data_out}, {prev_last, prev_keep, prev_data});
        end
        if (valid_out && !ready_out) check_val("in_blocked", 64'(ready_in), 0);
        prev_ostall = valid_out && !ready_out;
        prev_data = data_out; prev_keep = keep_out; prev_last = last_out;
        if (valid_out && ready_out) begin
          if (exp_out.size() == 0) begin
            check_val("out_extra", 64'(valid_out), 0);
          end else begin
            mon_e = exp_out.pop_front();
            check_val("out_data", 64'(data_out & byte_mask(mon_e.keep)), 64'(mon_e.data));
            check_val("out_keep", 64'(keep_out), 64'(mon_e.keep));
            check_val("out_last", 64'(last_out), 64'(mon_e.last));
          end
        end
`ifdef AXIS_STRIP_HDR_OUT_EN
        if (prev_hstall) check_val("hdr_hold", {valid_hdr, keep_hdr, data_hdr}, {1'b1, prev_hkeep, prev_hdata});
        prev_hstall = valid_hdr && !ready_hdr;
        prev_hdata = data_hdr; prev_hkeep = keep_hdr;
        if (valid_hdr && ready_hdr) begin
          if (exp_hdr.size() == 0) begin
            check_val("hdr_extra", 64'(valid_hdr), 0);
          end else begin
            mon_e = exp_hdr.pop_front();
            check_val("hdr_data", 64'(data_hdr & byte_mask(mon_e.keep)), 64'(mon_e.data));
            check_val("hdr_keep", 64'(keep_hdr), 64'(mon_e.keep));
          end
        end
`else
        check_val("hdr_off", {valid_hdr, keep_hdr, data_hdr}, 0);
`endif
        if (short_pkt) begin
          seen_short++;
          check_val("short_width", 64'(prev_short), 0);
        end
        prev_short = short_pkt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("rst");

    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run_packet(1, -1, 1'b0);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_packet(2, -1, 1'b0);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    run_packet(0, -1, 1'b0);
    pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_packet(4, -1, 1'b0);

    // ready_out held low for three cycles in the middle of a packet
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(8'h40 + i));
    fork
      run_packet(1, -1, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #2 stall_req = 1;
        repeat (3) @(posedge clk);
        #2 stall_req = 0;
      end
    join

    // reset in the middle of a streaming packet, then a clean packet
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(8'h80 + i));
    run_packet(1, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_out.delete();
    exp_hdr.delete();
    check_reset_outputs("mid_rst");
    pkt = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    run_packet(3, -1, 1'b0);

    bp_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 13);
      s = $urandom_range(0, 7);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      run_packet(s, -1, 1'b1);
    end

    t = 0;
    while ((exp_out.size() != 0 || exp_hdr.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    check_val("drain_out", 64'(exp_out.size()), 0);
    check_val("drain_hdr", 64'(exp_hdr.size()), 0);
    check_val("short_count", 64'(seen_short), 64'(exp_short));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
